dual_dispatch: RTL and testbench

- Dispatch stage directly downstream of the instruction queue.
- Accepts an instruction pair, decodes the RISC-V fields, allocates ROB tags, and issues up to two instructions per cycle to the reservation-station lanes.
- Dispatch is strictly in order: lane 2 never issues unless lane 1 issues in the same cycle.
- Drives the queue's dispatch_1_ready / dispatch_2_ready back-pressure.

---
 rtl/dual_dispatch.sv | 137 +++++++++++++
 tb/tb_dual_dispatch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_dispatch.sv
// dual_dispatch: two-entry holding buffer that decodes an instruction pair,
// allocates ROB tags and issues up to two instructions per cycle in order.
module dual_dispatch #(
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  instr1,
    input  logic [XLEN-1:0]  instr2,
    input  logic             instr_queue_empty,
    output logic             dispatch_1_ready,
    output logic             dispatch_2_ready,
    input  logic             fu_accept_1,
    input  logic             fu_accept_2,
    input  logic [TAG_W:0]   rob_free,
    output logic             d1_valid,
    output logic             d2_valid,
    output logic             d1_fire,
    output logic             d2_fire,
    output logic [6:0]       d1_opcode,
    output logic [6:0]       d2_opcode,
    output logic [4:0]       d1_rd,
    output logic [4:0]       d2_rd,
    output logic [4:0]       d1_rs1,
    output logic [4:0]       d2_rs1,
    output logic [4:0]       d1_rs2,
    output logic [4:0]       d2_rs2,
    output logic [2:0]       d1_funct3,
    output logic [2:0]       d2_funct3,
    output logic [6:0]       d1_funct7,
    output logic [6:0]       d2_funct7,
    output logic [XLEN-1:0]  d1_imm,
    output logic [XLEN-1:0]  d2_imm,
    output logic             d1_illegal,
    output logic             d2_illegal,
    output logic [TAG_W-1:0] d1_tag,
    output logic [TAG_W-1:0] d2_tag
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state;
    logic              h0_v, h1_v, n_h0_v, n_h1_v;
    logic [XLEN-1:0]   w0, w1, n_w0, n_w1;
    logic [TAG_W-1:0]  next_tag;
    logic [XLEN:0]     dec1, dec2;

    // Returns {illegal, imm}
    function automatic logic [XLEN:0] decode(input logic [XLEN-1:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                return {1'b0, {(XLEN-12){i[31]}}, i[31:20]};
            7'b0100011:
                return {1'b0, {(XLEN-12){i[31]}}, i[31:25], i[11:7]};
            7'b1100011:
                return {1'b0, {(XLEN-12){i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                return {1'b0, XLEN'($signed({i[31:12], 12'b0}))};
            7'b1101111:
                return {1'b0, {(XLEN-20){i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
            7'b0110011:
                return '0;
            default:
                return {1'b1, {XLEN{1'b0}}};
        endcase
    endfunction

    assign state = h1_v ? TWO : (h0_v ? ONE : EMPTY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h0_v     <= 1'b0;
            h1_v     <= 1'b0;
            w0       <= '0;
            w1       <= '0;
            next_tag <= '0;
        end else begin
            h0_v     <= n_h0_v;
            h1_v     <= n_h1_v;
            w0       <= n_w0;
            w1       <= n_w1;
            next_tag <= next_tag + TAG_W'(d1_fire) + TAG_W'(d2_fire);
        end
    end

    // Zero words are bubbles; a lone nonzero word always lands in H0.
    always_comb begin
        n_h0_v = h0_v;
        n_h1_v = h1_v;
        n_w0   = w0;
        n_w1   = w1;
        if (state == EMPTY && !instr_queue_empty) begin
            n_h0_v = (instr1 != '0) || (instr2 != '0);
            n_h1_v = (instr1 != '0) && (instr2 != '0);
            n_w0   = (instr1 != '0) ? instr1 : instr2;
            n_w1   = instr2;
        end else if (d2_fire) begin
            n_h0_v = 1'b0;
            n_h1_v = 1'b0;
        end else if (d1_fire) begin
            n_h0_v = h1_v;
            n_h1_v = 1'b0;
            n_w0   = w1;
        end
    end

    always_comb begin
        dispatch_1_ready = state == EMPTY;
        dispatch_2_ready = state == EMPTY;
        d1_valid   = h0_v;
        d2_valid   = h1_v;
        d1_fire    = h0_v && fu_accept_1 && (|rob_free);
        d2_fire    = h1_v && d1_fire && fu_accept_2 && (rob_free > (TAG_W+1)'(1));
        dec1       = decode(w0);
        dec2       = decode(w1);
        d1_opcode  = w0[6:0];
        d2_opcode  = w1[6:0];
        d1_rd      = w0[11:7];
        d2_rd      = w1[11:7];
        d1_rs1     = w0[19:15];
        d2_rs1     = w1[19:15];
        d1_rs2     = w0[24:20];
        d2_rs2     = w1[24:20];
        d1_funct3  = w0[14:12];
        d2_funct3  = w1[14:12];
        d1_funct7  = w0[31:25];
        d2_funct7  = w1[31:25];
        d1_imm     = dec1[XLEN-1:0];
        d2_imm     = dec2[XLEN-1:0];
        d1_illegal = dec1[XLEN];
        d2_illegal = dec2[XLEN];
        d1_tag     = next_tag;
        d2_tag     = next_tag + TAG_W'(1);
    end

    assert property (@(posedge clk) disable iff (reset) !(h1_v && !h0_v));
endmodule

// File: tb/tb_dual_dispatch.sv
// tb_dual_dispatch: directed and randomized checks of dual_dispatch against
// a queue-based reference model.
module tb_dual_dispatch;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr1, instr2;
    logic        instr_queue_empty, fu_accept_1, fu_accept_2;
    logic [4:0]  rob_free;
    logic        dispatch_1_ready, dispatch_2_ready;
    logic        d1_valid, d2_valid, d1_fire, d2_fire, d1_illegal, d2_illegal;
    logic [6:0]  d1_opcode, d2_opcode, d1_funct7, d2_funct7;
    logic [4:0]  d1_rd, d2_rd, d1_rs1, d2_rs1, d1_rs2, d2_rs2;
    logic [2:0]  d1_funct3, d2_funct3;
    logic [31:0] d1_imm, d2_imm;
    logic [3:0]  d1_tag, d2_tag;

    int errors = 0;
    int checks = 0;
    logic [31:0] held[$];
    int mtag = 0;
    logic [6:0] ops[10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    dual_dispatch #(.TAG_W(4), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .instr1(instr1), .instr2(instr2),
        .instr_queue_empty(instr_queue_empty),
        .dispatch_1_ready(dispatch_1_ready), .dispatch_2_ready(dispatch_2_ready),
        .fu_accept_1(fu_accept_1), .fu_accept_2(fu_accept_2), .rob_free(rob_free),
        .d1_valid(d1_valid), .d2_valid(d2_valid), .d1_fire(d1_fire), .d2_fire(d2_fire),
        .d1_opcode(d1_opcode), .d2_opcode(d2_opcode), .d1_rd(d1_rd), .d2_rd(d2_rd),
        .d1_rs1(d1_rs1), .d2_rs1(d2_rs1), .d1_rs2(d1_rs2), .d2_rs2(d2_rs2),
        .d1_funct3(d1_funct3), .d2_funct3(d2_funct3), .d1_funct7(d1_funct7), .d2_funct7(d2_funct7),
        .d1_imm(d1_imm), .d2_imm(d2_imm), .d1_illegal(d1_illegal), .d2_illegal(d2_illegal),
        .d1_tag(d1_tag), .d2_tag(d2_tag)
    );

    always #5 clk = ~clk;

    // Immediate built arithmetically from weighted bit groups; returns {illegal, imm}.
    function automatic logic [32:0] ref_dec(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: v = $signed(i) >>> 20;
            7'h23: v = (($signed(i) >>> 25) * 32) + int'(i[11:7]);
            7'h63: v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h37, 7'h17: v = int'(i & 32'hFFFFF000);
            7'h6F: v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            7'h33: v = 0;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, 32'(v)};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        if ($urandom_range(0, 7) == 0) return 32'h0;
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 9)];
        return w;
    endfunction

    // Advance the reference model by one clock edge, then move to the next falling edge.
    task automatic tick();
        bit e1, e2;
        e1 = held.size() > 0 && fu_accept_1 && rob_free >= 1;
        e2 = e1 && held.size() > 1 && fu_accept_2 && rob_free >= 2;
        if (held.size() == 0) begin
            if (!instr_queue_empty) begin
                if (instr1 != 0) held.push_back(instr1);
                if (instr2 != 0) held.push_back(instr2);
            end
        end else begin
            if (e1) void'(held.pop_front());
            if (e2) void'(held.pop_front());
        end
        mtag = (mtag + int'(e1) + int'(e2)) % 16;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        instr1 = 32'h00500093; instr2 = 32'h002081B3;
        instr_queue_empty = 1'b0; fu_accept_1 = 1'b1; fu_accept_2 = 1'b1; rob_free = 5'd8;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({dispatch_1_ready, dispatch_2_ready} !== 2'b11) begin
            errors++; $display("FAIL reset_ready: got %b expected 11", {dispatch_1_ready, dispatch_2_ready});
        end
        checks++;
        if ({d1_valid, d2_valid, d1_fire, d2_fire} !== 4'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0000", {d1_valid, d2_valid, d1_fire, d2_fire});
        end
        @(negedge clk);
        reset = 1'b0;
        held.delete();
        mtag = 0;
    endtask

    task automatic test_pair();
        instr1 = 32'h00500093; instr2 = 32'h002081B3;
        instr_queue_empty = 1'b0; fu_accept_1 = 1'b1; fu_accept_2 = 1'b1; rob_free = 5'd8;
        tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_fire, d2_fire, dispatch_1_ready} !== 3'b110) begin
            errors++; $display("FAIL pair_fire: got %b expected 110", {d1_fire, d2_fire, dispatch_1_ready});
        end
        checks++;
        if ({d1_rd, d1_imm, d1_tag} !== {5'd1, 32'd5, 4'd0}) begin
            errors++; $display("FAIL pair_lane1: got rd=%0d imm=%h tag=%0d expected 1 5 0", d1_rd, d1_imm, d1_tag);
        end
        checks++;
        if ({d2_rd, d2_rs1, d2_rs2, d2_tag} !== {5'd3, 5'd1, 5'd2, 4'd1}) begin
            errors++; $display("FAIL pair_lane2: got rd=%0d rs1=%0d rs2=%0d tag=%0d expected 3 1 2 1", d2_rd, d2_rs1, d2_rs2, d2_tag);
        end
        tick();
        #1;
        checks++;
        if ({dispatch_1_ready, dispatch_2_ready, d1_valid} !== 3'b110) begin
            errors++; $display("FAIL pair_ready_back: got %b expected 110", {dispatch_1_ready, dispatch_2_ready, d1_valid});
        end
    endtask

    task automatic test_split();
        instr_queue_empty = 1'b0; fu_accept_2 = 1'b0;
        tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_fire, d2_fire, d1_tag} !== {2'b10, 4'd2}) begin
            errors++; $display("FAIL split_first: got fire=%b tag=%0d expected 10 2", {d1_fire, d2_fire}, d1_tag);
        end
        tick();
        #1;
        checks++;
        if ({d1_valid, d2_valid, d1_fire, d1_rd, d1_tag} !== {3'b101, 5'd3, 4'd3}) begin
            errors++; $display("FAIL split_second: got v=%b f=%b rd=%0d tag=%0d expected 10 1 3 3", {d1_valid, d2_valid}, d1_fire, d1_rd, d1_tag);
        end
        tick();
        fu_accept_1 = 1'b0; fu_accept_2 = 1'b1; instr_queue_empty = 1'b0;
        tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_valid, d2_valid, d1_fire, d2_fire} !== 4'b1100) begin
            errors++; $display("FAIL no_accept1: got %b expected 1100", {d1_valid, d2_valid, d1_fire, d2_fire});
        end
    endtask

    task automatic test_rob_limit();
        fu_accept_1 = 1'b1; fu_accept_2 = 1'b1; rob_free = 5'd0;
        repeat (3) begin
            #1;
            checks++;
            if ({d1_valid, d2_valid, d1_fire, d2_fire, dispatch_1_ready} !== 5'b11000) begin
                errors++; $display("FAIL rob_zero_hold: got %b expected 11000", {d1_valid, d2_valid, d1_fire, d2_fire, dispatch_1_ready});
            end
            tick();
        end
        rob_free = 5'd1;
        #1;
        checks++;
        if ({d1_fire, d2_fire, d1_tag} !== {2'b10, 4'd4}) begin
            errors++; $display("FAIL rob_one: got fire=%b tag=%0d expected 10 4", {d1_fire, d2_fire}, d1_tag);
        end
        tick();
        rob_free = 5'd8;
        #1;
        checks++;
        if ({d1_fire, d2_fire, d1_tag, d1_rd} !== {2'b10, 4'd5, 5'd3}) begin
            errors++; $display("FAIL rob_refire: got fire=%b tag=%0d rd=%0d expected 10 5 3", {d1_fire, d2_fire}, d1_tag, d1_rd);
        end
        tick();
    endtask

    task automatic test_tag_wrap();
        repeat (4) begin
            instr_queue_empty = 1'b0; tick();
            instr_queue_empty = 1'b1; tick();
        end
        instr2 = 32'h0;
        instr_queue_empty = 1'b0; tick();
        instr_queue_empty = 1'b1; tick();
        instr2 = 32'h002081B3;
        instr_queue_empty = 1'b0; tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_fire, d2_fire, d1_tag, d2_tag} !== {2'b11, 4'd15, 4'd0}) begin
            errors++; $display("FAIL tag_wrap: got fire=%b tags=%0d,%0d expected 11 15,0", {d1_fire, d2_fire}, d1_tag, d2_tag);
        end
        tick();
        instr1 = 32'h0; instr2 = 32'hFFF00113;
        instr_queue_empty = 1'b0; tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_valid, d2_valid, d1_illegal, d1_rd, d1_imm, d1_tag} !== {3'b100, 5'd2, 32'hFFFFFFFF, 4'd1}) begin
            errors++; $display("FAIL bubble_load: got v=%b ill=%b rd=%0d imm=%h tag=%0d expected 10 0 2 ffffffff 1",
                               {d1_valid, d2_valid}, d1_illegal, d1_rd, d1_imm, d1_tag);
        end
        tick();
        instr1 = 32'h00500093;
        repeat (3) begin
            tick();
            #1;
            checks++;
            if ({dispatch_1_ready, d1_valid, d2_valid} !== 3'b100) begin
                errors++; $display("FAIL queue_empty_noload: got %b expected 100", {dispatch_1_ready, d1_valid, d2_valid});
            end
        end
    endtask

    task automatic test_reset_mid();
        instr1 = 32'h00500093; instr2 = 32'h002081B3;
        fu_accept_1 = 1'b1; fu_accept_2 = 1'b0; rob_free = 5'd8; instr_queue_empty = 1'b0;
        tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_valid, d2_valid, d1_fire} !== 3'b111) begin
            errors++; $display("FAIL mid_pre: got %b expected 111", {d1_valid, d2_valid, d1_fire});
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({dispatch_1_ready, dispatch_2_ready, d1_valid, d2_valid, d1_fire, d2_fire} !== 6'b110000) begin
            errors++; $display("FAIL mid_reset: got %b expected 110000", {dispatch_1_ready, dispatch_2_ready, d1_valid, d2_valid, d1_fire, d2_fire});
        end
        held.delete();
        mtag = 0;
        @(negedge clk);
        reset = 1'b0;
        fu_accept_2 = 1'b1; instr_queue_empty = 1'b0;
        tick();
        instr_queue_empty = 1'b1;
        #1;
        checks++;
        if ({d1_fire, d2_fire, d1_tag, d2_tag} !== {2'b11, 4'd0, 4'd1}) begin
            errors++; $display("FAIL mid_after: got fire=%b tags=%0d,%0d expected 11 0,1", {d1_fire, d2_fire}, d1_tag, d2_tag);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [32:0] d;
        bit e1, e2;
        for (int n = 0; n < 400; n++) begin
            instr1 = rand_instr(); instr2 = rand_instr();
            instr_queue_empty = ($urandom_range(0, 4) == 0);
            fu_accept_1 = ($urandom_range(0, 3) != 0);
            fu_accept_2 = ($urandom_range(0, 3) != 0);
            rob_free = 5'($urandom_range(0, 16));
            #1;
            e1 = held.size() > 0 && fu_accept_1 && rob_free >= 1;
            e2 = e1 && held.size() > 1 && fu_accept_2 && rob_free >= 2;
            checks++;
            if ({dispatch_1_ready, dispatch_2_ready, d1_valid, d2_valid, d1_fire, d2_fire} !==
                {held.size() == 0, held.size() == 0, held.size() > 0, held.size() > 1, e1, e2}) begin
                errors++; $display("FAIL rnd_ctrl[%0d]: got %b held=%0d expected fire %b%b", n,
                                   {dispatch_1_ready, dispatch_2_ready, d1_valid, d2_valid, d1_fire, d2_fire}, held.size(), e1, e2);
            end
            if (held.size() > 0) begin
                w = held[0]; d = ref_dec(w);
                checks++;
                if ({d1_opcode, d1_rd, d1_rs1, d1_rs2, d1_funct3, d1_funct7, d1_illegal, d1_imm, d1_tag} !==
                    {w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], d, 4'(mtag)}) begin
                    errors++; $display("FAIL rnd_lane1[%0d]: instr=%h got ill=%b imm=%h tag=%0d expected ill=%b imm=%h tag=%0d",
                                       n, w, d1_illegal, d1_imm, d1_tag, d[32], d[31:0], mtag);
                end
            end
            if (held.size() > 1) begin
                w = held[1]; d = ref_dec(w);
                checks++;
                if ({d2_opcode, d2_rd, d2_rs1, d2_rs2, d2_funct3, d2_funct7, d2_illegal, d2_imm, d2_tag} !==
                    {w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25], d, 4'((mtag + 1) % 16)}) begin
                    errors++; $display("FAIL rnd_lane2[%0d]: instr=%h got ill=%b imm=%h tag=%0d expected ill=%b imm=%h tag=%0d",
                                       n, w, d2_illegal, d2_imm, d2_tag, d[32], d[31:0], (mtag + 1) % 16);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_split();
        test_rob_limit();
        test_tag_wrap();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
